regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file.
- Shares that port between two requesters:
  - the pipeline writeback stage, which cannot be refused except via stall;
  - an auxiliary multi-cycle unit (multiplier/loader) using a req/ack handshake.
- Sequences a post-reset clear sweep, enforces the $zero write rule and bounds auxiliary starvation by stalling the pipeline.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- MAX_WAIT, 4, max consecutive cycles an aux request may lose before a forced grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we_i  in  1  writeback write request, single-cycle, never held.
- wb_addr_i  in  ADDR_W  writeback destination register.
- wb_data_i  in  DATA_W  writeback data.
- aux_req_i  in  1  aux request; held with addr/data stable until ack.
- aux_addr_i  in  ADDR_W  aux destination register.
- aux_data_i  in  DATA_W  aux data.
- aux_ack_o  out  1  one-cycle pulse: aux write issued.
- stall_o  out  1  pipeline freeze; while high, wb_we_i is ignored.
- init_busy_o  out  1  clear sweep in progress.
- rf_we_o  out  1  register-file write strobe.
- rf_waddr_o  out  ADDR_W  register-file write address.
- rf_wdata_o  out  DATA_W  register-file write data.

Behaviour:
- All outputs registered. Decision made in cycle N appears on rf_*/aux_ack_o in cycle N+1; the file writes at the end of N+1.
- Reset (sampled high at an edge), next cycle:
  - state=INIT, sweep counter=0, wait_cnt=0;
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, aux_ack_o=0;
  - stall_o=1, init_busy_o=1.
  - Reset mid-sweep or mid-handshake restarts the sweep; a pending aux request is dropped and must be re-presented.
- INIT state:
  - Each cycle issues rf_we_o=1, rf_waddr_o=counter, rf_wdata_o=0; counter increments.
  - After address 2^ADDR_W-1 is issued, go to RUN; stall_o and init_busy_o fall in the same cycle.
  - wb_we_i and aux_req_i are ignored; no ack.
- RUN state, per cycle, in priority order:
  1. aux_ack_o currently high: aux_req_i ignored this cycle (requester drops it).
  2. stall_o currently high: grant aux if requesting, else idle. wb_we_i is ignored.
  3. wb_we_i=1: grant WB.
  4. aux_req_i=1: grant aux.
  5. Otherwise idle (rf_we_o=0 next cycle).
- Starvation:
  - wait_cnt increments each RUN cycle where aux_req_i=1, rule 1 does not apply, and aux is not granted.
  - If wait_cnt==MAX_WAIT-1 and aux loses again, stall_o=1 next cycle for exactly one cycle, and aux wins there.
  - wait_cnt clears on aux grant or reset; saturates at MAX_WAIT-1.
- $zero rule:
  - Any RUN grant with address 0 yields rf_we_o=0; rf_waddr_o/rf_wdata_o still update.
  - An aux grant to address 0 is still acked.
- No ordering guarantee between WB and aux writes to the same register; ordering is the issuer's responsibility.

Optional Feature:
- RF_CLEAR_ON_RESET_EN defined: INIT sweep as above, 2^ADDR_W cycles.
- Not defined: reset goes directly to RUN; stall_o=0 and init_busy_o=0 one cycle after reset; the file keeps its own reset values.

Decomposition:
- Shared package (cpu_pkg): DATA_W/ADDR_W constants, state enum {ST_INIT, ST_RUN}, grant enum {GNT_NONE, GNT_WB, GNT_AUX, GNT_INIT}.
- One sub-module: rr_starve_counter (wait_cnt plus the force-grant flag), reused later by the memory-port arbiter.

Test Plan:
- Reset high 2 cycles, then low, with RF_CLEAR_ON_RESET_EN defined:
  - 32 consecutive cycles of rf_we_o=1, rf_waddr_o 0..31, data 0;
  - stall_o/init_busy_o high throughout, both low on cycle 33.
- RUN, wb_we_i=1, addr 3, data 12:
  - next cycle rf_we_o=1, rf_waddr_o=3, rf_wdata_o=12;
  - wb_we_i=1 with addr 0 → rf_we_o=0.
- aux_req_i=1 (addr 7, data 0xBEEF) with no WB traffic:
  - next cycle rf_we_o=1, addr 7, aux_ack_o=1;
  - requester holds req during the ack cycle → no second write.
- wb_we_i=1 every cycle, aux_req_i=1 (addr 9), MAX_WAIT=4:
  - WB wins 4 cycles, then stall_o=1 for one cycle;
  - rf write addr 9 and aux_ack_o follow, wait_cnt returns to 0.
- Assert reset during the sweep at counter=10, and separately during aux wait_cnt=2:
  - sweep restarts at address 0;
  - aux gets no ack until re-presented after INIT.
- RF_CLEAR_ON_RESET_EN undefined, same reset:
  - stall_o=0 one cycle after reset;
  - a WB write to addr 5 issues immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: register-file geometry, arbiter state and grant encodings.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_ADDR_W = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_AUX,
    GNT_INIT
  } gnt_e;

endpackage

// File: rtl/rr_starve_counter.sv
// Counts consecutive lost arbitration rounds for a requester and flags when the
// next loss must be turned into a forced grant.
module rr_starve_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_c
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             lose;

  assign lose    = req && !gnt;
  assign force_c = lose && (wait_cnt == CNT_MAX);

  // Saturating loss counter, cleared by a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (gnt) begin
      wait_cnt <= '0;
    end else if (lose && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port, sharing it between writeback and an aux unit.
// Define RF_CLEAR_ON_RESET_EN to zero every register with a sweep after reset.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              aux_req_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_data_i,
  output logic              aux_ack_o,
  output logic              stall_o,
  output logic              init_busy_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

`ifdef RF_CLEAR_ON_RESET_EN
  localparam state_e RST_STATE = ST_INIT;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_e RST_STATE = ST_RUN;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_e            state, state_nxt;
  gnt_e              gnt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] rf_waddr_nxt;
  logic [DATA_W-1:0] rf_wdata_nxt;
  logic              rf_we_nxt, aux_ack_nxt, stall_nxt, init_busy_nxt;
  logic              aux_elig, aux_gnt, force_c;

  // An aux request is invisible during the sweep and in the cycle it is acked.
  assign aux_elig = (state == ST_RUN) && aux_req_i && !aux_ack_o;
  assign aux_gnt  = (gnt == GNT_AUX);

  rr_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req    (aux_elig),
    .gnt    (aux_gnt),
    .force_c(force_c)
  );

  // Grant selection; a stalled pipeline leaves the port to aux only.
  always_comb begin
    gnt = GNT_NONE;
    if (state == ST_INIT) begin
      gnt = GNT_INIT;
    end else if (stall_o) begin
      gnt = aux_elig ? GNT_AUX : GNT_NONE;
    end else if (wb_we_i) begin
      gnt = GNT_WB;
    end else if (aux_elig) begin
      gnt = GNT_AUX;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rf_we_nxt     = 1'b0;
    rf_waddr_nxt  = rf_waddr_o;
    rf_wdata_nxt  = rf_wdata_o;
    aux_ack_nxt   = 1'b0;
    stall_nxt     = 1'b0;
    init_busy_nxt = 1'b0;

    if (state == ST_INIT) begin
      cnt_nxt       = cnt + ADDR_W'(1);
      stall_nxt     = 1'b1;
      init_busy_nxt = 1'b1;
      if (cnt == '1) begin
        state_nxt = ST_RUN;
      end
    end else begin
      stall_nxt = force_c;
    end

    // Register $zero is never written, but address/data still track the grant.
    case (gnt)
      GNT_INIT: begin
        rf_we_nxt    = 1'b1;
        rf_waddr_nxt = cnt;
        rf_wdata_nxt = '0;
      end
      GNT_WB: begin
        rf_we_nxt    = (wb_addr_i != '0);
        rf_waddr_nxt = wb_addr_i;
        rf_wdata_nxt = wb_data_i;
      end
      GNT_AUX: begin
        rf_we_nxt    = (aux_addr_i != '0);
        rf_waddr_nxt = aux_addr_i;
        rf_wdata_nxt = aux_data_i;
        aux_ack_nxt  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RST_STATE;
      cnt         <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      aux_ack_o   <= 1'b0;
      stall_o     <= RST_BUSY;
      init_busy_o <= RST_BUSY;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rf_we_o     <= rf_we_nxt;
      rf_waddr_o  <= rf_waddr_nxt;
      rf_wdata_o  <= rf_wdata_nxt;
      aux_ack_o   <= aux_ack_nxt;
      stall_o     <= stall_nxt;
      init_busy_o <= init_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; expectations follow RF_CLEAR_ON_RESET_EN.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        aux_req = 1'b0;
  logic [4:0]  aux_addr = '0;
  logic [31:0] aux_data = '0;
  logic        aux_ack_o, stall_o, init_busy_o, rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic        stall;
    logic        busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  obs_t act;
  exp_t e;

  regfile_write_arbiter #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_we_i    (wb_we),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .aux_req_i  (aux_req),
    .aux_addr_i (aux_addr),
    .aux_data_i (aux_data),
    .aux_ack_o  (aux_ack_o),
    .stall_o    (stall_o),
    .init_busy_o(init_busy_o),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expectation tagged for this cycle; otherwise no write/ack may appear.
  always @(negedge clk) begin
    act = {rf_we_o, rf_waddr_o, rf_wdata_o, aux_ack_o, stall_o, init_busy_o};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_check cyc=%0d", e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs cyc=%0d got we=%b addr=%0d data=%h ack=%b stall=%b busy=%b want we=%b addr=%0d data=%h ack=%b stall=%b busy=%b",
                 cyc, act.we, act.addr, act.data, act.ack, act.stall, act.busy,
                 e.o.we, e.o.addr, e.o.data, e.o.ack, e.o.stall, e.o.busy);
      end
    end else if (cyc > 0) begin
      checks++;
      if (rf_we_o !== 1'b0 || aux_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got we=%b ack=%b addr=%0d want we=0 ack=0",
                 cyc, rf_we_o, aux_ack_o, rf_waddr_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input logic ack,
                           input logic stall, input logic busy);
    exp_t x;
    x.cyc = c;
    x.o   = {we, addr, data, ack, stall, busy};
    q.push_back(x);
  endtask

  // Reset for n cycles, then (with the sweep) expect 32 zero writes, optionally cut short.
  task automatic do_reset(input int n, input int abort_at);
    int r;
    reset = 1'b1;
    wb_we = 1'b0;
    repeat (n) tick();
    r = cyc;
`ifdef RF_CLEAR_ON_RESET_EN
    expect_at(r, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (abort_at < 0 || i < abort_at) expect_at(r + 1 + i, 1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 1'b1);
    end
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
    end else begin
      expect_at(r + 33, 1'b0, 5'd31, 32'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 33; i++) begin
        if (i == 31) aux_req = 1'b0;
        tick();
      end
    end
`else
    expect_at(r, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    reset   = 1'b0;
    aux_req = 1'b0;
    if (abort_at > 0) tick();
`endif
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_we   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    expect_at(cyc + 1, (addr != 5'd0), addr, data, 1'b0, 1'b0, 1'b0);
    tick();
    wb_we = 1'b0;
  endtask

  // WB hogs the port while aux waits: four losses, one stall cycle, forced aux grant.
  task automatic starve_run(input logic [4:0] aaddr, input logic [31:0] adata, input int base);
    aux_req  = 1'b1;
    aux_addr = aaddr;
    aux_data = adata;
    for (int i = 0; i < 4; i++) begin
      wb_we   = 1'b1;
      wb_addr = 5'(base + i);
      wb_data = 32'(100 + base + i);
      expect_at(cyc + 1, 1'b1, 5'(base + i), 32'(100 + base + i), 1'b0, (i == 3), 1'b0);
      tick();
    end
    wb_addr = 5'd31;
    wb_data = 32'hDEAD_0000;
    expect_at(cyc + 1, (aaddr != 5'd0), aaddr, adata, 1'b1, 1'b0, 1'b0);
    tick();
    wb_addr = 5'(base + 4);
    wb_data = 32'(100 + base + 4);
    expect_at(cyc + 1, 1'b1, 5'(base + 4), 32'(100 + base + 4), 1'b0, 1'b0, 1'b0);
    tick();
    wb_we   = 1'b0;
    aux_req = 1'b0;
    tick();
  endtask

  initial begin
    do_reset(2, -1);

    // First write after reset / sweep.
    wb_write(5'd5, 32'h55);
    tick();

    // Plain WB write, then a WB write to $zero.
    wb_write(5'd3, 32'd12);
    wb_write(5'd0, 32'h77);
    tick();

    // Aux alone; request still held through the ack cycle must not rewrite.
    aux_req  = 1'b1;
    aux_addr = 5'd7;
    aux_data = 32'hBEEF;
    expect_at(cyc + 1, 1'b1, 5'd7, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    expect_at(cyc + 1, 1'b0, 5'd7, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    tick();
    aux_req = 1'b0;
    tick();

    // Starvation bound, twice back to back (second proves the counter cleared), then aux to $zero.
    starve_run(5'd9, 32'h99, 10);
    starve_run(5'd0, 32'h1234, 20);

`ifdef RF_CLEAR_ON_RESET_EN
    // Reset in the middle of the sweep while aux is requesting.
    reset = 1'b1;
    tick();
    aux_req  = 1'b1;
    aux_addr = 5'd7;
    aux_data = 32'h5A;
    do_reset(0, 10);
    do_reset(1, -1);
    aux_req = 1'b1;
    expect_at(cyc + 1, 1'b1, 5'd7, 32'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    aux_req = 1'b0;
    tick();
`endif

    // Reset while aux has lost twice; counter must restart from zero.
    aux_req  = 1'b1;
    aux_addr = 5'd9;
    aux_data = 32'h99;
    for (int i = 0; i < 2; i++) begin
      wb_we   = 1'b1;
      wb_addr = 5'(1 + i);
      wb_data = 32'(200 + i);
      expect_at(cyc + 1, 1'b1, 5'(1 + i), 32'(200 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    do_reset(1, -1);
    starve_run(5'd9, 32'h99, 10);

    repeat (4) tick();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL never_checked cyc=%0d", e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
